// File: rtl/rf_op_sequencer.sv
// Register-file operation sequencer: accepts one ALU command, reads two sources,
// executes, and writes the result back over four cycles (IDLE/READ/EXEC/WRITE).
module rf_op_sequencer (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [4:0]         cmd_rs,
  input  logic [4:0]         cmd_rt,
  input  logic [4:0]         cmd_rd,
  output logic [4:0]         rf_r1_addr,
  output logic [4:0]         rf_r2_addr,
  input  logic signed [31:0] rf_r1_data,
  input  logic signed [31:0] rf_r2_data,
  output logic [4:0]         rf_w_addr,
  output logic [31:0]        rf_w_data,
  output logic               rf_we,
  output logic [31:0]        result,
  output logic               done
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_SLT = 3'b101;
  localparam logic [OP_W-1:0] OP_SLL = 3'b110;
  localparam logic [OP_W-1:0] OP_SRA = 3'b111;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [ADDR_W-1:0]   r1_addr_d, r2_addr_d, w_addr_d;
  logic [DATA_W-1:0]   w_data_d, result_d;
  logic                we_d, done_d, ready_d;
  logic [DATA_W-1:0]   alu_c;
  logic [4:0]          shamt_c;

  // Combinational ALU on the registered read data; only B[4:0] drives shifts.
  always_comb begin
    alu_c   = '0;
    shamt_c = rf_r2_data[4:0];
    case (op_q)
      OP_ADD:  alu_c = rf_r1_data + rf_r2_data;
      OP_SUB:  alu_c = rf_r1_data - rf_r2_data;
      OP_AND:  alu_c = rf_r1_data & rf_r2_data;
      OP_OR:   alu_c = rf_r1_data | rf_r2_data;
      OP_XOR:  alu_c = rf_r1_data ^ rf_r2_data;
      OP_SLT:  alu_c = {31'b0, (rf_r1_data < rf_r2_data)};
      OP_SLL:  alu_c = rf_r1_data << shamt_c;
      OP_SRA:  alu_c = rf_r1_data >>> shamt_c;
      default: alu_c = '0;
    endcase
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    r1_addr_d = rf_r1_addr;
    r2_addr_d = rf_r2_addr;
    w_addr_d  = rf_w_addr;
    w_data_d  = rf_w_data;
    result_d  = result;
    we_d      = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d      = cmd_op;
          rd_d      = cmd_rd;
          r1_addr_d = cmd_rs;
          r2_addr_d = cmd_rt;
          state_d   = READ;
        end
      end
      READ: state_d = EXEC;
      EXEC: begin
        result_d = alu_c;
        w_addr_d = rd_q;
        w_data_d = alu_c;
        we_d     = (rd_q != '0);
        done_d   = 1'b1;
        state_d  = WRITE;
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      rf_r1_addr <= '0;
      rf_r2_addr <= '0;
      rf_w_addr  <= '0;
      rf_w_data  <= '0;
      rf_we      <= 1'b0;
      result     <= '0;
      done       <= 1'b0;
      cmd_ready  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rf_r1_addr <= r1_addr_d;
      rf_r2_addr <= r2_addr_d;
      rf_w_addr  <= w_addr_d;
      rf_w_data  <= w_data_d;
      rf_we      <= we_d;
      result     <= result_d;
      done       <= done_d;
      cmd_ready  <= ready_d;
    end
  end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed bench for rf_op_sequencer with a behavioural register file.
module tb_rf_op_sequencer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_op;
  logic [4:0]         cmd_rs, cmd_rt, cmd_rd;
  logic [4:0]         rf_r1_addr, rf_r2_addr;
  logic signed [31:0] rf_r1_data, rf_r2_data;
  logic [4:0]         rf_w_addr;
  logic [31:0]        rf_w_data;
  logic               rf_we;
  logic [31:0]        result;
  logic               done;

  logic               tb_we;
  logic [4:0]         tb_waddr;
  logic [31:0]        tb_wdata;
  logic [31:0]        rf [32];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_op_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rs     (cmd_rs),
    .cmd_rt     (cmd_rt),
    .cmd_rd     (cmd_rd),
    .rf_r1_addr (rf_r1_addr),
    .rf_r2_addr (rf_r2_addr),
    .rf_r1_data (rf_r1_data),
    .rf_r2_data (rf_r2_data),
    .rf_w_addr  (rf_w_addr),
    .rf_w_data  (rf_w_data),
    .rf_we      (rf_we),
    .result     (result),
    .done       (done)
  );

  // Register file: synchronous read one clock after the address, r0 reads zero.
  always @(posedge clk) begin
    if (rf_we) rf[rf_w_addr] <= rf_w_data;
    else if (tb_we) rf[tb_waddr] <= tb_wdata;
    rf_r1_data <= (rf_r1_addr == 5'd0) ? 32'd0 : rf[rf_r1_addr];
    rf_r2_data <= (rf_r2_addr == 5'd0) ? 32'd0 : rf[rf_r2_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Issue one command from IDLE and check the full four-cycle sequence.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] exp);
    check({tag, ".ready_idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, ".ready_read"}, 32'(cmd_ready), 32'd0);
    check({tag, ".we_read"}, 32'(rf_we), 32'd0);
    @(negedge clk);
    check({tag, ".done_exec"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, ".we"}, 32'(rf_we), (rd != 5'd0) ? 32'd1 : 32'd0);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".w_addr"}, 32'(rf_w_addr), 32'(rd));
    check({tag, ".w_data"}, rf_w_data, exp);
    check({tag, ".result"}, result, exp);
    @(negedge clk);
    check({tag, ".we_after"}, 32'(rf_we), 32'd0);
    check({tag, ".done_after"}, 32'(done), 32'd0);
    check({tag, ".ready_after"}, 32'(cmd_ready), 32'd1);
    check({tag, ".result_hold"}, result, exp);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0;
    tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    @(negedge clk);
    check("rst.ready", 32'(cmd_ready), 32'd0);
    check("rst.we", 32'(rf_we), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.r1_addr", 32'(rf_r1_addr), 32'd0);

    load(5'd1, 32'd5);
    load(5'd2, 32'hFFFF_FFF9);
    load(5'd6, 32'h8000_0000);
    load(5'd7, 32'd1);
    load(5'd8, 32'hFFFF_FFFF);
    load(5'd9, 32'd33);
    load(5'd10, 32'd4);

    rst_n = 1'b1;
    #1 check("rel.ready_low", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("rel.ready_first_edge", 32'(cmd_ready), 32'd1);

    run_cmd("add", 3'b000, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFE);
    run_cmd("sub", 3'b001, 5'd6, 5'd7, 5'd11, 32'h7FFF_FFFF);
    run_cmd("slt_neg", 3'b101, 5'd8, 5'd7, 5'd12, 32'd1);
    run_cmd("slt_pos", 3'b101, 5'd7, 5'd8, 5'd12, 32'd0);
    run_cmd("sll", 3'b110, 5'd7, 5'd9, 5'd13, 32'd2);
    run_cmd("sra", 3'b111, 5'd6, 5'd10, 5'd14, 32'hF800_0000);
    run_cmd("and", 3'b010, 5'd1, 5'd2, 5'd15, 32'd1);
    run_cmd("or", 3'b011, 5'd1, 5'd2, 5'd16, 32'hFFFF_FFFD);
    run_cmd("xor", 3'b100, 5'd1, 5'd2, 5'd17, 32'hFFFF_FFFC);
    run_cmd("rd0", 3'b000, 5'd1, 5'd1, 5'd0, 32'd10);

    // Back-to-back with cmd_valid held; second command depends on the first.
    check("b2b.ready0", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_rd = 5'd4;
    @(negedge clk);
    cmd_rs = 5'd4; cmd_rt = 5'd4; cmd_rd = 5'd5;
    check("b2b.ready1", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("b2b.ready2", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("b2b.ready3", 32'(cmd_ready), 32'd0);
    check("b2b.w_addr_a", 32'(rf_w_addr), 32'd4);
    check("b2b.w_data_a", rf_w_data, 32'hFFFF_FFFE);
    @(negedge clk);
    check("b2b.ready4", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b.ready_b", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("b2b.we_b", 32'(rf_we), 32'd1);
    check("b2b.w_addr_b", 32'(rf_w_addr), 32'd5);
    check("b2b.w_data_b", rf_w_data, 32'hFFFF_FFFC);
    @(negedge clk);
    check("b2b.rf5", rf[5], 32'hFFFF_FFFC);
    check("b2b.ready_end", 32'(cmd_ready), 32'd1);

    // Reset asserted during EXEC aborts the command.
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_rs = 5'd1; cmd_rt = 5'd1; cmd_rd = 5'd20;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.ready", 32'(cmd_ready), 32'd0);
    check("abort.we", 32'(rf_we), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.result", result, 32'd0);
    check("abort.r1_addr", 32'(rf_r1_addr), 32'd0);
    check("abort.w_addr", 32'(rf_w_addr), 32'd0);
    check("abort.w_data", rf_w_data, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort.we_hold", 32'(rf_we), 32'd0);
      check("abort.done_hold", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    #1 check("abort.ready_rel", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("abort.ready_back", 32'(cmd_ready), 32'd1);
    check("abort.we_after", 32'(rf_we), 32'd0);
    check("abort.done_after", 32'(done), 32'd0);
    @(negedge clk);
    check("abort.we_idle", 32'(rf_we), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_op_sequencer.md
RF_OP_SEQUENCER -- requirements
Module: rf_op_sequencer

Interface
REQ-001 SHALL have: clk  input  1  clock, all state updates on rising edge.
REQ-002 SHALL have: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: cmd_valid  input  1  command request.
REQ-004 SHALL have: cmd_ready  output  1  sequencer can accept a command.
REQ-005 SHALL have: cmd_op  input  3  operation code.
REQ-006 SHALL have: cmd_rs / cmd_rt / cmd_rd  input  5 each  source1, source2 and destination register indices.
REQ-007 SHALL have: rf_r1_addr / rf_r2_addr  output  5 each  register-file read addresses.
REQ-008 SHALL have: rf_r1_data / rf_r2_data  input  32 signed each  register-file read data; registered one clock after the address.
REQ-009 SHALL have: rf_w_addr  output  5, rf_w_data  output  32, rf_we  output  1  register-file write port.
REQ-010 SHALL have: result  output  32  last computed value; done  output  1  one-cycle completion pulse.

Function
REQ-011 SHALL implement a four-state FSM: IDLE, READ, EXEC, WRITE.
REQ-012 IDLE: cmd_ready=1; a handshake (cmd_valid & cmd_ready at edge E0) SHALL latch cmd_op/cmd_rd, register rf_r1_addr=cmd_rs and rf_r2_addr=cmd_rt, and go to READ.
REQ-013 IDLE without cmd_valid SHALL hold state; command inputs are ignored whenever cmd_ready=0.
REQ-014 READ: one cycle, read addresses held; at edge E1 SHALL go to EXEC unconditionally (register file captures data at E1).
REQ-015 EXEC: rf_r1_data/rf_r2_data valid; at E2 SHALL register result=f(op,A,B) and go to WRITE.
REQ-016 WRITE: rf_we=1, rf_w_addr=latched rd, rf_w_data=result, done=1, for exactly one cycle; at E3 SHALL return to IDLE.
REQ-017 rf_we, done and cmd_ready SHALL be registered (Moore) outputs; rf_we and done are 0 outside WRITE.
REQ-018 Latency SHALL be: handshake edge E0 -> rf_we high in the cycle after E2 -> write committed at E3; maximum throughput is one command per 4 cycles.
REQ-019 rf_r1_addr/rf_r2_addr SHALL hold their values until the next handshake.
REQ-020 Op encoding SHALL be: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SLT (signed A<B ? 1 : 0), 110 SLL (A << B[4:0]), 111 SRA (A >>> B[4:0]).
REQ-021 ADD/SUB SHALL wrap modulo 2^32 with no overflow flag; shifts SHALL use only B[4:0].
REQ-022 If latched rd==0, WRITE SHALL keep rf_we=0 but still pulse done and update result.
REQ-023 result SHALL hold its value until the next EXEC edge.
REQ-024 A command accepted immediately after a WRITE that targets one of its sources SHALL read the newly written value, because its read is sampled at or after E3 of the previous command.

Reset
REQ-025 While rst_n=0: state=IDLE, cmd_ready=0, rf_r1_addr=rf_r2_addr=rf_w_addr=0, rf_w_data=0, rf_we=0, result=0, done=0.
REQ-026 cmd_ready SHALL rise at the first clock edge after rst_n deasserts.
REQ-027 Reset asserted in any state SHALL abort the command immediately; no write is issued and no done pulse occurs.

Verification
REQ-028 ADD r3=r1+r2 with r1=5, r2=-7 -> after 3 edges, one cycle with rf_we=1, rf_w_addr=3, rf_w_data=0xFFFFFFFE, done=1.
REQ-029 SUB with A=0x80000000, B=1 -> 0x7FFFFFFF; SLT with A=-1, B=1 -> 1; SLT with A=1, B=-1 -> 0.
REQ-030 SLL with A=1, B=33 -> 2 (shift 1); SRA with A=0x80000000, B=4 -> 0xF8000000.
REQ-031 cmd_valid held high: "ADD r4=r1+r2" then "ADD r5=r4+r4" -> cmd_ready pattern 1,0,0,0,1; second command writes 2*(r1+r2) to r5.
REQ-032 rd=0 -> rf_we stays 0, done pulses once, result updated.
REQ-033 rst_n low during EXEC -> rf_we never asserts, all outputs 0; cmd_ready returns to 1 one edge after release.
